// File: rtl/uart_tx_fifo_reader.sv
// UART transmitter that pops bytes from a first-word-fall-through FIFO and sends 16x-oversampled frames.
// Optional even-parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_fifo_reader #(
  parameter int DBIT    = 8,
  parameter int SB_TICK = 16,
  parameter int DVSR    = 163,
  parameter int DVSR_W  = 8
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            tx_en,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_r_data,
  output logic            fifo_rd,
  output logic            tx,
  output logic            tx_busy,
  output logic            tx_done_tick
);

  localparam int TICK_W = ($clog2(SB_TICK) > 4) ? $clog2(SB_TICK) : 4;
  localparam int NB_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd3;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd4;
`endif

  logic [2:0]        state;
  logic [DVSR_W-1:0] baud_cnt;
  logic [TICK_W-1:0] tick_cnt;
  logic [NB_W-1:0]   bit_cnt;
  logic [DBIT-1:0]   shift;
  logic              s_tick;
  logic              bit_last_tick;
  logic              stop_last_tick;
`ifdef UART_TX_PARITY_EN
  logic              par;
`endif

  // Pop is gated by reset so nothing leaves the FIFO while the block is held.
  always_comb begin
    fifo_rd        = reset_n && (state == IDLE) && tx_en && !fifo_empty;
    s_tick         = (state != IDLE) && (baud_cnt == DVSR_W'(DVSR - 1));
    bit_last_tick  = s_tick && (tick_cnt == TICK_W'(15));
    stop_last_tick = s_tick && (tick_cnt == TICK_W'(SB_TICK - 1));
  end

  // tx is loaded with the level of the state being entered, so the pin changes on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= IDLE;
      baud_cnt     <= '0;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      tx           <= 1'b1;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par          <= 1'b0;
`endif
    end else begin
      tx_done_tick <= 1'b0;
      if (state == IDLE || s_tick)
        baud_cnt <= '0;
      else
        baud_cnt <= baud_cnt + 1'b1;
      if (s_tick)
        tick_cnt <= tick_cnt + 1'b1;

      case (state)
        IDLE: begin
          tx       <= 1'b1;
          tick_cnt <= '0;
          if (fifo_rd) begin
            shift   <= fifo_r_data;
`ifdef UART_TX_PARITY_EN
            par     <= ^fifo_r_data;
`endif
            state   <= START;
            tx      <= 1'b0;
            tx_busy <= 1'b1;
          end
        end
        START: begin
          if (bit_last_tick) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            state    <= DATA;
            tx       <= shift[0];
          end
        end
        DATA: begin
          if (bit_last_tick) begin
            tick_cnt <= '0;
            shift    <= shift >> 1;
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == NB_W'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= par;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              tx <= shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_last_tick) begin
            tick_cnt <= '0;
            state    <= STOP;
            tx       <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (stop_last_tick) begin
            tick_cnt     <= '0;
            state        <= IDLE;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo_reader.sv
// Scoreboard bench for uart_tx_fifo_reader: bytes pushed into a FIFO model are expected on the serial line.
module tb_uart_tx_fifo_reader;

  localparam int DV  = 2;
  localparam int BIT = 16 * DV;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n = 1'b0;
  logic       tx_en = 1'b0;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_r_data = 8'h00;
  logic       fifo_rd, tx, tx_busy, tx_done_tick;

  logic       fifo_empty32 = 1'b1;
  logic [7:0] fifo_r_data32 = 8'h00;
  logic       fifo_rd32, tx32, tx_busy32, tx_done_tick32;

  uart_tx_fifo_reader #(.DBIT(8), .SB_TICK(16), .DVSR(DV), .DVSR_W(8)) u_dut (
    .clk(clk), .reset_n(reset_n), .tx_en(tx_en), .fifo_empty(fifo_empty),
    .fifo_r_data(fifo_r_data), .fifo_rd(fifo_rd), .tx(tx), .tx_busy(tx_busy),
    .tx_done_tick(tx_done_tick)
  );

  uart_tx_fifo_reader #(.DBIT(8), .SB_TICK(32), .DVSR(DV), .DVSR_W(8)) u_dut32 (
    .clk(clk), .reset_n(reset_n), .tx_en(tx_en), .fifo_empty(fifo_empty32),
    .fifo_r_data(fifo_r_data32), .fifo_rd(fifo_rd32), .tx(tx32), .tx_busy(tx_busy32),
    .tx_done_tick(tx_done_tick32)
  );

  logic [7:0] fifo_q[$];
  logic [7:0] fifo_q32[$];
  logic [7:0] exp_q[$];

  int n_vec = 0;
  int n_err = 0;
  int rd_cnt = 0, rd_in_rst = 0, rd_dbl = 0, done_cnt = 0, done_dbl = 0;
  logic rd_prev = 1'b0, done_prev = 1'b0;

  // FIFO models: pop on the strobe, present the new head at the falling edge.
  always @(posedge clk) begin
    if (fifo_rd && fifo_q.size() > 0) void'(fifo_q.pop_front());
    if (fifo_rd32 && fifo_q32.size() > 0) void'(fifo_q32.pop_front());
    if (fifo_rd) rd_cnt <= rd_cnt + 1;
    if (fifo_rd && !reset_n) rd_in_rst <= rd_in_rst + 1;
    if (fifo_rd && rd_prev) rd_dbl <= rd_dbl + 1;
    if (tx_done_tick) done_cnt <= done_cnt + 1;
    if (tx_done_tick && done_prev) done_dbl <= done_dbl + 1;
    rd_prev   <= fifo_rd;
    done_prev <= tx_done_tick;
  end

  always @(negedge clk) begin
    fifo_empty    <= (fifo_q.size() == 0);
    fifo_r_data   <= (fifo_q.size() == 0) ? 8'h00 : fifo_q[0];
    fifo_empty32  <= (fifo_q32.size() == 0);
    fifo_r_data32 <= (fifo_q32.size() == 0) ? 8'h00 : fifo_q32[0];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
  endtask

  task automatic wait_start(output int gap);
    gap = -1;
    for (int i = 1; i <= 3000; i++) begin
      @(posedge clk);
      #1;
      if (tx === 1'b0) begin
        gap = i;
        return;
      end
    end
    check_val("start_timeout", 32'd1, 32'd0);
  endtask

  task automatic check_frame(input bit clr_en, output int gap);
    logic [7:0] b, got;
    int n;
    got = 8'h00;
    wait_start(gap);
    if (gap < 0) return;
    if (exp_q.size() == 0) begin
      check_val("sb_underflow", 32'd1, 32'd0);
      return;
    end
    b = exp_q.pop_front();
    check_val("busy_start", tx_busy, 1);
    tick(BIT / 2);
    check_val("start_bit", tx, 0);
    if (clr_en) tx_en = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick(BIT);
      got[k] = tx;
    end
    check_val("data", got, b);
`ifdef UART_TX_PARITY_EN
    tick(BIT);
    check_val("parity", tx, ^b);
`endif
    tick(BIT / 2);
    check_val("stop_bit", tx, 1);
    check_val("busy_stop", tx_busy, 1);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!tx_done_tick && n < 300);
    check_val("stop_len", n, 16 * DV);
    check_val("busy_end", tx_busy, 0);
  endtask

  initial begin
    int g, rd0, d0, txlow, busyc, n;
    logic [7:0] lost;

    // Reset held with data waiting: no pop, idle outputs.
    tx_en = 1'b1;
    push(8'hA5);
    tick(5);
    check_val("rst_tx", tx, 1);
    check_val("rst_busy", tx_busy, 0);
    check_val("rst_done", tx_done_tick, 0);
    check_val("rst_rd", fifo_rd, 0);
    check_val("rst_no_pop", rd_in_rst, 0);
    rd0 = rd_cnt;
    reset_n = 1'b1;
    check_frame(0, g);
    check_val("single_pop", rd_cnt - rd0, 1);

    // Back-to-back frames: one idle clock between them.
    rd0 = rd_cnt;
    d0  = done_cnt;
    push(8'h00);
    push(8'hFF);
    check_frame(0, g);
    check_frame(0, g);
    check_val("b2b_gap", g, 1);
    check_val("b2b_pops", rd_cnt - rd0, 2);
    check_val("b2b_done", done_cnt - d0, 2);

    // tx_en low with data waiting, then empty FIFO with tx_en high.
    tx_en = 1'b0;
    push(8'h12);
    rd0 = rd_cnt; txlow = 0; busyc = 0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      if (tx !== 1'b1) txlow++;
      if (tx_busy !== 1'b0) busyc++;
    end
    check_val("dis_pops", rd_cnt - rd0, 0);
    check_val("dis_tx_low", txlow, 0);
    check_val("dis_busy", busyc, 0);
    tx_en = 1'b1;
    check_frame(0, g);
    rd0 = rd_cnt; txlow = 0;
    for (int i = 0; i < 200; i++) begin
      tick(1);
      if (tx !== 1'b1) txlow++;
    end
    check_val("empty_pops", rd_cnt - rd0, 0);
    check_val("empty_tx_low", txlow, 0);

    // tx_en dropped mid-frame: frame completes, next byte stays queued.
    rd0 = rd_cnt;
    push(8'h5A);
    push(8'h77);
    check_frame(1, g);
    tick(200);
    check_val("en_drop_pops", rd_cnt - rd0, 1);
    check_val("en_drop_left", fifo_q.size(), 1);
    tx_en = 1'b1;
    check_frame(0, g);

    // Reset during data bit 3 of 0x3C.
    push(8'h3C);
    wait_start(g);
    tick(BIT / 2 + 4 * BIT);
    check_val("mid_bit3", tx, 1);
    reset_n = 1'b0;
    lost = exp_q.pop_front();
    push(8'h55);
    tick(1);
    check_val("mid_rst_tx", tx, 1);
    check_val("mid_rst_busy", tx_busy, 0);
    tick(3);
    check_val("mid_rst_no_pop", rd_in_rst, 0);
    check_val("mid_rst_fifo", fifo_q.size(), 1);
    reset_n = 1'b1;
    check_frame(0, g);

    // Parity-relevant bytes.
    push(8'h07);
    check_frame(0, g);
    push(8'h03);
    check_frame(0, g);
    check_val("done_width", done_dbl, 0);
    check_val("rd_width", rd_dbl, 0);

    // Two stop bits on the SB_TICK=32 instance.
    fifo_q32.push_back(8'h01);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (tx32 !== 1'b0 && n < 100);
    check_val("sb32_start", tx32, 0);
    tick((9 + PAR) * BIT - 1);
    check_val("sb32_last_bit", tx32, (PAR == 1) ? 1 : 0);
    tick(1);
    check_val("sb32_stop", tx32, 1);
    n = 0;
    do begin
      tick(1);
      n++;
    end while (!tx_done_tick32 && n < 300);
    check_val("sb32_stop_len", n, 32 * DV);
    check_val("sb32_busy_end", tx_busy32, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
